// File: rtl/split_join_mc.sv
// ============================================================================
// Module   : split_join_mc
// Purpose  : Per-warp IPDOM divergence stacks with ready/valid request and
//            response sides, overflow/underflow pulses, per-warp flush and
//            per-warp depth status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module split_join_mc #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int STACK_DEPTH = (NUM_THREADS > 1) ? NUM_THREADS - 1 : 1,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CW         = $clog2(2 * STACK_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NW_WIDTH-1:0]       req_wid,
    input  logic                      req_is_split,
    input  logic                      req_is_dvg,
    input  logic [NUM_THREADS-1:0]    req_then_tmask,
    input  logic [NUM_THREADS-1:0]    req_else_tmask,
    input  logic [XLEN-1:0]           req_else_pc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [NW_WIDTH-1:0]       rsp_wid,
    output logic                      rsp_is_dvg,
    output logic                      rsp_is_else,
    output logic [NUM_THREADS-1:0]    rsp_tmask,
    output logic [XLEN-1:0]           rsp_pc,
    input  logic                      flush_valid,
    input  logic [NW_WIDTH-1:0]       flush_wid,
    output logic                      err_overflow,
    output logic                      err_underflow,
    output logic [NUM_WARPS-1:0]      warp_empty,
    output logic [NUM_WARPS*CW-1:0]   warp_depth
);

    localparam int              ENTRIES    = 2 * STACK_DEPTH;
    // A push adds two entries, so it only fits while cnt <= ENTRIES-2.
    localparam logic [CW-1:0]   PUSH_LIMIT = CW'(ENTRIES - 2);

    // Per-warp stack storage (no reset: contents are only read below cnt)
    logic [NUM_THREADS-1:0] stk_tmask_q [NUM_WARPS][ENTRIES];
    logic [XLEN-1:0]        stk_pc_q    [NUM_WARPS][ENTRIES];
    logic                   stk_else_q  [NUM_WARPS][ENTRIES];

    logic [CW-1:0]          cnt_q [NUM_WARPS];
    logic [CW-1:0]          cnt_d [NUM_WARPS];

    logic                   rsp_valid_q,   rsp_valid_d;
    logic [NW_WIDTH-1:0]    rsp_wid_q,     rsp_wid_d;
    logic                   rsp_is_dvg_q,  rsp_is_dvg_d;
    logic                   rsp_is_else_q, rsp_is_else_d;
    logic [NUM_THREADS-1:0] rsp_tmask_q,   rsp_tmask_d;
    logic [XLEN-1:0]        rsp_pc_q,      rsp_pc_d;
    logic                   err_ovf_q,     err_ovf_d;
    logic                   err_unf_q,     err_unf_d;

    logic                   req_accept;
    logic [CW-1:0]          sel_cnt;
    logic [CW-1:0]          top_idx;
    logic [CW-1:0]          push_hi_idx;
    logic                   dvg_split;
    logic                   is_join;
    logic                   do_push;
    logic                   do_pop;

    // A flush on the requesting warp stalls that request; a pending response
    // only blocks new requests while the consumer is not taking it.
    assign req_ready  = (!rsp_valid_q || rsp_ready) && !(flush_valid && (flush_wid == req_wid));
    assign req_accept = req_valid && req_ready;

    assign sel_cnt     = cnt_q[req_wid];
    assign top_idx     = sel_cnt - CW'(1);
    assign push_hi_idx = sel_cnt + CW'(1);

    // Decode the accepted request into stack operations and error pulses
    always_comb begin
        dvg_split = req_accept && req_is_split && req_is_dvg;
        is_join   = req_accept && !req_is_split;
        do_push   = dvg_split && (sel_cnt <= PUSH_LIMIT);
        do_pop    = is_join && req_is_dvg && (sel_cnt != '0);
        err_ovf_d = dvg_split && (sel_cnt > PUSH_LIMIT);
        err_unf_d = is_join && req_is_dvg && (sel_cnt == '0);
    end

    // Next entry count per warp; flush and a same-warp request never coincide
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_d[w] = cnt_q[w];
            if (flush_valid && (flush_wid == NW_WIDTH'(w))) begin
                cnt_d[w] = '0;
            end else if (req_wid == NW_WIDTH'(w)) begin
                if (do_push) begin
                    cnt_d[w] = cnt_q[w] + CW'(2);
                end else if (do_pop) begin
                    cnt_d[w] = cnt_q[w] - CW'(1);
                end
            end
        end
    end

    // Response register: load on any accepted join, drop on handshake
    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_wid_d     = rsp_wid_q;
        rsp_is_dvg_d  = rsp_is_dvg_q;
        rsp_is_else_d = rsp_is_else_q;
        rsp_tmask_d   = rsp_tmask_q;
        rsp_pc_d      = rsp_pc_q;
        if (is_join) begin
            rsp_valid_d   = 1'b1;
            rsp_wid_d     = req_wid;
            rsp_is_dvg_d  = do_pop;
            rsp_is_else_d = do_pop ? stk_else_q[req_wid][top_idx]  : 1'b0;
            rsp_tmask_d   = do_pop ? stk_tmask_q[req_wid][top_idx] : '0;
            rsp_pc_d      = do_pop ? stk_pc_q[req_wid][top_idx]    : '0;
        end else if (rsp_ready) begin
            rsp_valid_d   = 1'b0;
        end
    end

    // Divergent split writes the reconvergence entry, then the else entry on top
    always_ff @(posedge clk) begin
        if (do_push) begin
            stk_tmask_q[req_wid][sel_cnt]     <= req_then_tmask | req_else_tmask;
            stk_pc_q[req_wid][sel_cnt]        <= '0;
            stk_else_q[req_wid][sel_cnt]      <= 1'b0;
            stk_tmask_q[req_wid][push_hi_idx] <= req_else_tmask;
            stk_pc_q[req_wid][push_hi_idx]    <= req_else_pc;
            stk_else_q[req_wid][push_hi_idx]  <= 1'b1;
        end
    end

    // Control state: counters, response and error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= '0;
            end
            rsp_valid_q   <= 1'b0;
            rsp_wid_q     <= '0;
            rsp_is_dvg_q  <= 1'b0;
            rsp_is_else_q <= 1'b0;
            rsp_tmask_q   <= '0;
            rsp_pc_q      <= '0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= cnt_d[w];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_wid_q     <= rsp_wid_d;
            rsp_is_dvg_q  <= rsp_is_dvg_d;
            rsp_is_else_q <= rsp_is_else_d;
            rsp_tmask_q   <= rsp_tmask_d;
            rsp_pc_q      <= rsp_pc_d;
            err_ovf_q     <= err_ovf_d;
            err_unf_q     <= err_unf_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_wid       = rsp_wid_q;
    assign rsp_is_dvg    = rsp_is_dvg_q;
    assign rsp_is_else   = rsp_is_else_q;
    assign rsp_tmask     = rsp_tmask_q;
    assign rsp_pc        = rsp_pc_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

    generate
        for (genvar g = 0; g < NUM_WARPS; g++) begin : g_status
            assign warp_empty[g]          = (cnt_q[g] == '0);
            assign warp_depth[g*CW +: CW] = cnt_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_split_join_mc.sv
// ============================================================================
// Module   : tb_split_join_mc
// Purpose  : Self-checking bench for split_join_mc using a stack model and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_split_join_mc;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int XL  = 32;
    localparam int ENT = 6;
    localparam int CW  = 3;

    typedef struct packed {
        logic [1:0]    wid;
        logic          dvg;
        logic          is_else;
        logic [NT-1:0] tmask;
        logic [XL-1:0] pc;
    } rsp_t;

    logic           clk;
    logic           reset_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_wid;
    logic           req_is_split;
    logic           req_is_dvg;
    logic [NT-1:0]  req_then_tmask;
    logic [NT-1:0]  req_else_tmask;
    logic [XL-1:0]  req_else_pc;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_wid;
    logic           rsp_is_dvg;
    logic           rsp_is_else;
    logic [NT-1:0]  rsp_tmask;
    logic [XL-1:0]  rsp_pc;
    logic           flush_valid;
    logic [1:0]     flush_wid;
    logic           err_overflow;
    logic           err_underflow;
    logic [NW-1:0]  warp_empty;
    logic [NW*CW-1:0] warp_depth;

    split_join_mc dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wid       (req_wid),
        .req_is_split  (req_is_split),
        .req_is_dvg    (req_is_dvg),
        .req_then_tmask(req_then_tmask),
        .req_else_tmask(req_else_tmask),
        .req_else_pc   (req_else_pc),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_wid       (rsp_wid),
        .rsp_is_dvg    (rsp_is_dvg),
        .rsp_is_else   (rsp_is_else),
        .rsp_tmask     (rsp_tmask),
        .rsp_pc        (rsp_pc),
        .flush_valid   (flush_valid),
        .flush_wid     (flush_wid),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .warp_empty    (warp_empty),
        .warp_depth    (warp_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-warp stacks and the queue of expected responses
    logic [NT-1:0] m_tm [NW][ENT];
    logic [XL-1:0] m_pc [NW][ENT];
    logic          m_el [NW][ENT];
    int            m_cnt [NW];
    rsp_t          exp_q [$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic nxt_ovf;
        logic nxt_unf;
        rsp_t r;
        int   w;
        if (!reset_n) begin
            for (int i = 0; i < NW; i++) m_cnt[i] = 0;
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            nxt_ovf = 1'b0;
            nxt_unf = 1'b0;
            exp_rdy = (exp_q.size() == 0 || rsp_ready) && !(flush_valid && flush_wid == req_wid);
            check_value("rsp_valid", rsp_valid, exp_q.size() != 0);
            check_value("req_ready", req_ready, exp_rdy);
            check_value("err_overflow", err_overflow, exp_ovf);
            check_value("err_underflow", err_underflow, exp_unf);
            for (int i = 0; i < NW; i++) begin
                check_value("warp_depth", warp_depth[i*CW +: CW], m_cnt[i]);
                check_value("warp_empty", warp_empty[i], m_cnt[i] == 0);
            end
            if (rsp_valid && exp_q.size() != 0) begin
                r = exp_q[0];
                check_value("rsp_wid", rsp_wid, r.wid);
                check_value("rsp_is_dvg", rsp_is_dvg, r.dvg);
                check_value("rsp_is_else", rsp_is_else, r.is_else);
                check_value("rsp_tmask", rsp_tmask, r.tmask);
                check_value("rsp_pc", rsp_pc, r.pc);
                if (rsp_ready) void'(exp_q.pop_front());
            end
            if (req_valid && exp_rdy) begin
                w = int'(req_wid);
                if (req_is_split && req_is_dvg) begin
                    if (m_cnt[w] > ENT - 2) begin
                        nxt_ovf = 1'b1;
                    end else begin
                        m_tm[w][m_cnt[w]]   = req_then_tmask | req_else_tmask;
                        m_pc[w][m_cnt[w]]   = '0;
                        m_el[w][m_cnt[w]]   = 1'b0;
                        m_tm[w][m_cnt[w]+1] = req_else_tmask;
                        m_pc[w][m_cnt[w]+1] = req_else_pc;
                        m_el[w][m_cnt[w]+1] = 1'b1;
                        m_cnt[w] += 2;
                    end
                end else if (!req_is_split) begin
                    r = '{wid: req_wid, dvg: 1'b0, is_else: 1'b0, tmask: '0, pc: '0};
                    if (req_is_dvg && m_cnt[w] > 0) begin
                        m_cnt[w] -= 1;
                        r.dvg     = 1'b1;
                        r.is_else = m_el[w][m_cnt[w]];
                        r.tmask   = m_tm[w][m_cnt[w]];
                        r.pc      = m_pc[w][m_cnt[w]];
                    end else if (req_is_dvg) begin
                        nxt_unf = 1'b1;
                    end
                    exp_q.push_back(r);
                end
            end
            if (flush_valid) m_cnt[int'(flush_wid)] = 0;
            exp_ovf = nxt_ovf;
            exp_unf = nxt_unf;
        end
    end

    // Present one request and hold it until accepted; returns at posedge+1
    task automatic do_req(input logic [1:0] wid, input logic split, input logic dvg,
                          input logic [NT-1:0] tm, input logic [NT-1:0] em, input logic [XL-1:0] pc);
        logic accepted;
        accepted       = 1'b0;
        req_valid      = 1'b1;
        req_wid        = wid;
        req_is_split   = split;
        req_is_dvg     = dvg;
        req_then_tmask = tm;
        req_else_tmask = em;
        req_else_pc    = pc;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
            end else if (i >= 2) begin
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        end
        if (!accepted) check_value("req_accept_timeout", accepted, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_wid = '0; req_is_split = 1'b0; req_is_dvg = 1'b0;
        req_then_tmask = '0; req_else_tmask = '0; req_else_pc = '0; rsp_ready = 1'b1;
        flush_valid = 1'b0; flush_wid = '0;
        idle(3);
        check_value("reset_rsp_valid", rsp_valid, 1'b0);
        check_value("reset_depth", warp_depth, '0);
        check_value("reset_empty", warp_empty, 4'hF);
        reset_n = 1'b1;
        idle(1);

        // Basic split then two joins on warp 1
        do_req(2'd1, 1'b1, 1'b1, 4'b0011, 4'b1100, 32'h100);
        check_value("t1_depth1", warp_depth[5:3], 3'd2);
        check_value("t1_empty", warp_empty, 4'b1101);
        check_value("t1_no_rsp", rsp_valid, 1'b0);
        do_req(2'd1, 1'b0, 1'b1, '0, '0, '0);
        check_value("t2_rsp1_else", rsp_is_else, 1'b1);
        check_value("t2_rsp1_tmask", rsp_tmask, 4'b1100);
        check_value("t2_rsp1_pc", rsp_pc, 32'h100);
        do_req(2'd1, 1'b0, 1'b1, '0, '0, '0);
        check_value("t2_rsp2_else", rsp_is_else, 1'b0);
        check_value("t2_rsp2_tmask", rsp_tmask, 4'b1111);
        check_value("t2_rsp2_pc", rsp_pc, 32'h0);
        check_value("t2_depth1", warp_depth[5:3], 3'd0);

        // Overflow then underflow on warp 0
        for (int i = 0; i < 4; i++) do_req(2'd0, 1'b1, 1'b1, 4'(i), 4'(i + 8), 32'h40 * (i + 1));
        check_value("ovf_pulse", err_overflow, 1'b1);
        check_value("ovf_depth0", warp_depth[2:0], 3'd6);
        for (int i = 0; i < 7; i++) do_req(2'd0, 1'b0, 1'b1, '0, '0, '0);
        check_value("unf_pulse", err_underflow, 1'b1);
        check_value("unf_rsp_dvg", rsp_is_dvg, 1'b0);
        idle(1);

        // Backpressure: response held for three cycles, next join blocked
        do_req(2'd3, 1'b1, 1'b1, 4'b0101, 4'b1010, 32'h200);
        rsp_ready = 1'b0;
        do_req(2'd3, 1'b0, 1'b1, '0, '0, '0);
        req_valid = 1'b1; req_wid = 2'd3; req_is_split = 1'b0; req_is_dvg = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_value("stall_req_ready", req_ready, 1'b0);
            check_value("stall_tmask", rsp_tmask, 4'b1010);
            check_value("stall_depth3", warp_depth[11:9], 3'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_value("b2b_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_value("b2b_tmask", rsp_tmask, 4'b1111);
        idle(1);

        // Flush warp 2 with a same-warp request stalled, then a different warp
        do_req(2'd2, 1'b1, 1'b1, 4'b0001, 4'b0010, 32'h300);
        do_req(2'd3, 1'b1, 1'b1, 4'b1000, 4'b0100, 32'h380);
        flush_valid = 1'b1; flush_wid = 2'd2;
        req_valid = 1'b1; req_wid = 2'd2; req_is_split = 1'b1; req_is_dvg = 1'b1;
        @(negedge clk);
        check_value("flush_same_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        check_value("flush_depth2", warp_depth[8:6], 3'd0);
        req_wid = 2'd3; req_is_split = 1'b0;
        @(negedge clk);
        check_value("flush_other_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; flush_valid = 1'b0;
        check_value("flush_other_tmask", rsp_tmask, 4'b0100);
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            do_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   4'($urandom), 4'($urandom), $urandom);
        end
        rsp_ready = 1'b1;
        idle(3);
        check_value("rand_drain", exp_q.size(), 0);

        // Reset while a response is pending and warp 0 holds 4 entries
        flush_valid = 1'b1; flush_wid = 2'd0;
        idle(1);
        flush_valid = 1'b0;
        do_req(2'd0, 1'b1, 1'b1, 4'b0011, 4'b0100, 32'h500);
        do_req(2'd0, 1'b1, 1'b1, 4'b0001, 4'b0010, 32'h540);
        rsp_ready = 1'b0;
        do_req(2'd1, 1'b0, 1'b0, '0, '0, '0);
        check_value("pre_rst_valid", rsp_valid, 1'b1);
        check_value("pre_rst_depth0", warp_depth[2:0], 3'd4);
        reset_n = 1'b0;
        #1;
        check_value("rst_rsp_valid", rsp_valid, 1'b0);
        check_value("rst_depth", warp_depth, '0);
        check_value("rst_empty", warp_empty, 4'hF);
        idle(2);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
